muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS datapath. It extends the combinational ALU path with multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Sits beside ALU: operands from Registers RS/RT data; hi_o/lo_o feed the MFHI/MFLO write-back mux.
- Control stalls the PC while busy_o is high.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be even and >= 4
HILO_RST, 0, reset value loaded into HI and LO

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
start_i  in  1  request; sampled only in IDLE
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
data1_i  in  WIDTH  rs operand (multiplicand / dividend)
data2_i  in  WIDTH  rt operand (multiplier / divisor)
hi_we_i  in  1  MTHI write enable
lo_we_i  in  1  MTLO write enable
wdata_i  in  WIDTH  MTHI/MTLO data
busy_o  out  1  operation in flight (state != IDLE)
done_o  out  1  one-cycle pulse; HI/LO updated this cycle
div0_o  out  1  valid with done_o; divide by zero
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset: only on a clock edge with rst_i=0.
  - State IDLE; HI=LO=HILO_RST; busy_o=0, done_o=0, div0_o=0.
  - Any in-flight operation is abandoned, with no HI/LO update.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE: on start_i=1, latch op, operand magnitudes and sign flags (signed ops only), clear iteration counter, go to CALC.
- CALC: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIX (1 cycle): apply sign correction, write HI/LO, assert done_o, return to IDLE.
- Latency: start sampled at edge E0; HI/LO and done_o change at edge E0+WIDTH+1. busy_o is high from E0 through E0+WIDTH+1.
- Back-to-back: start_i is accepted in the cycle done_o is high, because state is already IDLE.
- start_i while busy: ignored, not queued.
- Multiply result: {HI,LO} = full 2*WIDTH product (two's complement for MULT).
- Divide result: LO = quotient, truncated toward zero; HI = remainder, taking the sign of the dividend.
- Overflow: DIV of -2^(WIDTH-1) by -1 gives LO = -2^(WIDTH-1), HI = 0.
- Divide by zero: LO = all ones, HI = data1_i unmodified, div0_o=1 with done_o.
- MTHI/MTLO:
  - Honoured only in IDLE, with next-edge update; ignored while busy.
  - If hi_we_i/lo_we_i and start_i are both asserted in IDLE, the write lands now and is later overwritten by the result.
- div0_o holds its value until the next done_o or reset.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - Multiply leaves CALC as soon as the remaining multiplier bits are all zero; the remaining shifts are applied in FIX.
  - Divide by zero skips CALC: FIX runs the cycle after start, latency 1.
  - Latency varies from 1 to WIDTH+1.
- Undefined: fixed latency WIDTH+1 for every op.
- Results are identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding typedef and constants OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state typedef (IDLE, CALC, FIX)
- One sub-module, muldiv_sign_fix: combinational negate-if for the 2*WIDTH product and the quotient/remainder pair.
- Counter width is $clog2(WIDTH+1), local to muldiv_unit.

Test Plan:
- MULT 0xFFFFFFFD x 0x00000005 -> at E0+33: done_o=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy_o low next cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; a second start issued in the done cycle is accepted.
- DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x00000064 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, div0_o=1. Latency is 33 cycles without MULDIV_EARLY_OUT_EN, 1 cycle with it.
- MTLO 0x1234 in IDLE -> lo_o=0x1234 next cycle. MTHI during CALC -> hi_o unchanged by the write and equals the op result at done.
- rst_i=0 for one edge at CALC cycle 10 -> IDLE, HI=LO=0, busy_o=0, no done_o pulse afterwards.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding and FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package muldiv_pkg;

    // Matches the op_i encoding presented by the decoder.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign correction of the unsigned iteration result: negate-if on product or quotient/remainder.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc_i    : raw 2*WIDTH result; product, or {remainder, quotient} for divides
//   is_div_i : 1 selects the quotient/remainder interpretation of acc_i
//   neg_a_i  : negate the product (multiply) or the quotient (divide)
//   neg_b_i  : negate the remainder (divide only)
//   hi_o     : value destined for HI
//   lo_o     : value destined for LO
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               is_div_i,
    input  logic               neg_a_i,
    input  logic               neg_b_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        // The product is negated as one 2*WIDTH quantity so the borrow
        // from LO into HI is carried correctly.
        prod_fix = neg_a_i ? -acc_i : acc_i;
        quot_fix = neg_a_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem_fix  = neg_b_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];

        if (is_div_i) begin
            hi_o = rem_fix;
            lo_o = quot_fix;
        end else begin
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
            lo_o = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// Latency: WIDTH+1 cycles from start to done_o (1..WIDTH+1 with MULDIV_EARLY_OUT_EN).
// Backpressure: busy_o high while in flight; start_i and HI/LO writes are ignored while busy.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   defined   : multiply leaves CALC once the remaining multiplier bits are zero,
//               divide-by-zero goes straight to FIX (latency 1)
//   undefined : every op takes exactly WIDTH+1 cycles
//
// Ports:
//   clk_i, rst_i        : clock (rising edge), synchronous active-low reset
//   start_i, op_i       : op request, sampled in IDLE only
//   data1_i, data2_i    : rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi_we_i, lo_we_i    : MTHI / MTLO enables, data on wdata_i, honoured in IDLE only
//   busy_o              : op in flight
//   done_o              : one-cycle pulse in the cycle HI/LO first show the result
//   div0_o              : divide-by-zero flag, updated with done_o
//   hi_o, lo_o          : HI / LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    // Registered state
    state_e             state_q, state_d;
    op_e                op_q,    op_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    // Multiply: {partial product, remaining multiplier}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   opnd_q,  opnd_d;
    logic               neg_a_q, neg_a_d;   // negate product / quotient
    logic               neg_b_q, neg_b_d;   // negate remainder
    logic               dz_q,    dz_d;      // current op is a divide by zero
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               done_q,  done_d;
    logic               div0_q,  div0_d;

    // Request decode
    op_e              op_in;
    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    // Datapath for one iteration
    logic [CW-1:0]      cnt_nxt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_rs;
    logic               div_ge;
    logic [WIDTH:0]     div_sub;
    logic [WIDTH:0]     div_rem;
    logic [2*WIDTH-1:0] div_step;
    logic               unused_div_rem_msb;

    // Result path
    logic               q_is_div;
    logic [2*WIDTH-1:0] fix_acc;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        op_in     = op_e'(op_i);
        in_signed = op_is_signed(op_in);
        in_div    = op_is_div(op_in);
        mag1      = (in_signed && data1_i[WIDTH-1]) ? -data1_i : data1_i;
        mag2      = (in_signed && data2_i[WIDTH-1]) ? -data2_i : data2_i;
    end

    always_comb begin
        cnt_nxt = cnt_q + CW'(1);

        // Shift-add: add the multiplicand when the current multiplier bit
        // is set, then shift the whole accumulator right by one. The sum
        // carries one extra bit that lands in the accumulator MSB.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder
        // and subtract the divisor when it fits. The remainder stays below
        // the divisor, so the shifted value needs one extra bit only.
        div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (div_rs >= {1'b0, opnd_q});
        div_sub  = div_rs - {1'b0, opnd_q};
        div_rem  = div_ge ? div_sub : div_rs;
        div_step = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        unused_div_rem_msb = div_rem[WIDTH];
    end

    assign q_is_div = op_is_div(op_q);

`ifdef MULDIV_EARLY_OUT_EN
    // Low WIDTH-cnt_nxt bits of the accumulator still hold unconsumed multiplier bits.
    logic [WIDTH-1:0] rem_mask;
    logic [CW-1:0]    fix_shift;

    assign rem_mask  = {WIDTH{1'b1}} >> cnt_nxt;
    assign fix_shift = CNT_LAST - cnt_q;
    // An early-exited multiply still owes WIDTH-cnt right shifts; they
    // only move zeros, so they collapse into one barrel shift here.
    assign fix_acc   = q_is_div ? acc_q : (acc_q >> fix_shift);
`else
    assign fix_acc   = acc_q;
`endif

    muldiv_sign_fix #(
        .WIDTH    (WIDTH)
    ) u_sign_fix (
        .acc_i    (fix_acc),
        .is_div_i (q_is_div),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = div0_q;

        case (state_q)
            ST_IDLE: begin
                // A write here is overwritten by the result if start_i
                // is also high, since FIX writes HI/LO last.
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    state_d = ST_CALC;
                    op_d    = op_in;
                    cnt_d   = '0;
                    neg_a_d = in_signed && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
                    neg_b_d = in_signed && data1_i[WIDTH-1];
                    dz_d    = in_div && (data2_i == '0);
                    if (in_div) begin
                        acc_d  = {{WIDTH{1'b0}}, mag1};
                        opnd_d = mag2;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag2};
                        opnd_d = mag1;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    // The remainder half must already equal |dividend| so
                    // the sign fix restores the original data1_i into HI.
                    if (in_div && (data2_i == '0)) begin
                        state_d = ST_FIX;
                        acc_d   = {mag1, {WIDTH{1'b1}}};
                    end
`endif
                end
            end

            ST_CALC: begin
                cnt_d = cnt_nxt;
                acc_d = q_is_div ? div_step : mul_step;
                if (cnt_nxt == CNT_LAST) state_d = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                if (!q_is_div && ((mul_step[WIDTH-1:0] & rem_mask) == '0)) begin
                    state_d = ST_FIX;
                end
`endif
            end

            ST_FIX: begin
                hi_d    = fix_hi;
                // Divide by zero: the restoring loop leaves |dividend| in
                // the remainder, but the quotient sign fix would spoil the
                // all-ones quotient, so force it.
                lo_d    = dz_q ? {WIDTH{1'b1}} : fix_lo;
                done_d  = 1'b1;
                div0_d  = dz_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= HILO_RST;
            lo_q    <= HILO_RST;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign div0_o = div0_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases plus random ops.
// Latency: expected start-to-done latency computed from the op rules.
// Backpressure: every wait on done_o is bounded.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic         hi_we_i;
    logic         lo_we_i;
    logic [W-1:0] wdata_i;
    logic         busy_o;
    logic         done_o;
    logic         div0_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    muldiv_unit #(
        .WIDTH    (W),
        .HILO_RST (32'h0)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .hi_we_i  (hi_we_i),
        .lo_we_i  (lo_we_i),
        .wdata_i  (wdata_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .div0_o   (div0_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    // Architectural reference: plain 64-bit and integer arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] hi,
                                      output logic [W-1:0] lo, output logic dz);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            C_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = sp;
            end
            C_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                {hi, lo} = up;
            end
            default: begin
                if (b == '0) begin
                    dz = 1'b1;
                    lo = '1;
                    hi = a;
                end else if (op == C_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else if (op == C_DIV) begin
                    sa = a;
                    sb = b;
                    lo = sa / sb;
                    hi = sa % sb;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Edges from the start-sampling edge to the edge that raises done_o.
    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        logic [W-1:0] m;
        int           k;
        m = (op == C_MULT && b[W-1]) ? -b : b;
        k = 1;
        for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (op[1] && b == '0) return 1;
        if (!op[1]) return k + 1;
        return W + 1;
`else
        return (k > 0) ? W + 1 : W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] pick_operand(input int sel, input logic [W-1:0] r);
        case (sel)
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return r;
        endcase
    endfunction

    // Present a request and let the start-sampling edge pass.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_i = 1'b1;
        op_i    = op;
        data1_i = a;
        data2_i = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Count edges until done_o; busy_o must stay high until then.
    task automatic wait_done(output int lat, output logic got, output logic busy_ok);
        lat     = 0;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (!got && lat < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            @(posedge clk_i);
            #1;
            lat++;
            if (done_o) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        start_i = 1'b0;
        op_i    = 2'b00;
        data1_i = '0;
        data2_i = '0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({busy_o, done_o, div0_o} !== 3'b000)
            $display("FAIL reset_flags: busy/done/div0=%b required 000", {busy_o, done_o, div0_o});
        else n_pass++;
        n_checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0)
            $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi_o, lo_o);
        else n_pass++;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_directed();
        logic [1:0]   op;
        logic [W-1:0] a, b, ehi, elo;
        logic         edz, got, bok;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin op = C_MULT;  a = 32'hFFFF_FFFD; b = 32'h5;
                         ehi = 32'hFFFF_FFFF; elo = 32'hFFFF_FFF1; edz = 1'b0; end
                1: begin op = C_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
                         ehi = 32'hFFFF_FFFE; elo = 32'h0000_0001; edz = 1'b0; end
                2: begin op = C_DIV;   a = 32'hFFFF_FFF9; b = 32'h2;
                         ehi = 32'hFFFF_FFFF; elo = 32'hFFFF_FFFD; edz = 1'b0; end
                3: begin op = C_DIV;   a = 32'h8000_0000; b = 32'hFFFF_FFFF;
                         ehi = 32'h0;         elo = 32'h8000_0000; edz = 1'b0; end
                4: begin op = C_DIVU;  a = 32'h64;        b = 32'h0;
                         ehi = 32'h64;        elo = 32'hFFFF_FFFF; edz = 1'b1; end
                default: begin op = C_DIV; a = 32'hFFFF_FFF9; b = 32'h0;
                         ehi = 32'hFFFF_FFF9; elo = 32'hFFFF_FFFF; edz = 1'b1; end
            endcase
            launch(op, a, b);
            wait_done(lat, got, bok);
            n_checks++;
            if (got !== 1'b1) $display("FAIL dir%0d_done: done_o not seen in 100 cycles", i);
            else n_pass++;
            n_checks++;
            if (lat != exp_lat(op, b)) $display("FAIL dir%0d_latency: %0d cycles required %0d", i, lat, exp_lat(op, b));
            else n_pass++;
            n_checks++;
            if (hi_o !== ehi || lo_o !== elo)
                $display("FAIL dir%0d_result: hi=%h lo=%h required hi=%h lo=%h", i, hi_o, lo_o, ehi, elo);
            else n_pass++;
            n_checks++;
            if (div0_o !== edz) $display("FAIL dir%0d_div0: %b required %b", i, div0_o, edz);
            else n_pass++;
            n_checks++;
            if (bok !== 1'b1 || busy_o !== 1'b0)
                $display("FAIL dir%0d_busy: busy_during=%b busy_at_done=%b required 1/0", i, bok, busy_o);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] b2, ehi, elo;
        logic         edz, got, bok;
        int           lat;
        launch(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, got, bok);
        // Issue the next op in the very cycle done_o is high.
        b2 = $urandom_range(1, 1000);
        launch(C_DIVU, 32'd987654321, b2);
        wait_done(lat, got, bok);
        ref_model(C_DIVU, 32'd987654321, b2, ehi, elo, edz);
        n_checks++;
        if (got !== 1'b1 || lat != exp_lat(C_DIVU, b2))
            $display("FAIL b2b_accept: done=%b after %0d cycles required 1 after %0d", got, lat, exp_lat(C_DIVU, b2));
        else n_pass++;
        n_checks++;
        if (hi_o !== ehi || lo_o !== elo)
            $display("FAIL b2b_result: hi=%h lo=%h required hi=%h lo=%h", hi_o, lo_o, ehi, elo);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic got, bok;
        int   lat, extra;
        launch(C_MULTU, 32'h7, 32'h8000_0009);
        repeat (5) @(posedge clk_i);
        #1;
        launch(C_DIV, 32'd100, 32'd3);
        wait_done(lat, got, bok);
        n_checks++;
        if (got !== 1'b1 || hi_o !== 32'h3 || lo_o !== 32'h8000_003F)
            $display("FAIL busy_ignore_result: done=%b hi=%h lo=%h required 1 3 8000003f", got, hi_o, lo_o);
        else n_pass++;
        extra = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL busy_ignore_queued: %0d busy/done cycles after op required 0", extra);
        else n_pass++;
    endtask

    task automatic test_mthi_mtlo();
        logic         got, bok;
        int           lat;
        logic [W-1:0] hi_before;
        hi_before = hi_o;
        lo_we_i = 1'b1;
        wdata_i = 32'h1234;
        @(posedge clk_i);
        #1;
        lo_we_i = 1'b0;
        n_checks++;
        if (lo_o !== 32'h1234 || hi_o !== hi_before)
            $display("FAIL mtlo_idle: lo=%h hi=%h required lo=00001234 hi=%h", lo_o, hi_o, hi_before);
        else n_pass++;
        hi_we_i = 1'b1;
        wdata_i = 32'hCAFE;
        @(posedge clk_i);
        #1;
        hi_we_i = 1'b0;
        n_checks++;
        if (hi_o !== 32'hCAFE) $display("FAIL mthi_idle: hi=%h required 0000cafe", hi_o);
        else n_pass++;
        // MTLO together with start: lands now, result overwrites later.
        lo_we_i = 1'b1;
        wdata_i = 32'hABCD;
        launch(C_MULTU, 32'h3, 32'h8000_0001);
        lo_we_i = 1'b0;
        n_checks++;
        if (lo_o !== 32'hABCD) $display("FAIL mtlo_with_start: lo=%h required 0000abcd", lo_o);
        else n_pass++;
        repeat (3) @(posedge clk_i);
        #1;
        hi_we_i = 1'b1;
        wdata_i = 32'h5555;
        @(posedge clk_i);
        #1;
        hi_we_i = 1'b0;
        n_checks++;
        if (hi_o !== 32'hCAFE) $display("FAIL mthi_busy: hi=%h required 0000cafe", hi_o);
        else n_pass++;
        wait_done(lat, got, bok);
        n_checks++;
        if (got !== 1'b1 || hi_o !== 32'h1 || lo_o !== 32'h8000_0003)
            $display("FAIL mthi_busy_result: done=%b hi=%h lo=%h required 1 1 80000003", got, hi_o, lo_o);
        else n_pass++;
        // div0_o holds across idle cycles and MTLO, clears at next done.
        launch(C_DIVU, 32'h64, 32'h0);
        wait_done(lat, got, bok);
        lo_we_i = 1'b1;
        wdata_i = 32'h77;
        repeat (3) @(posedge clk_i);
        #1;
        lo_we_i = 1'b0;
        n_checks++;
        if (div0_o !== 1'b1) $display("FAIL div0_hold: div0=%b required 1", div0_o);
        else n_pass++;
        launch(C_MULT, 32'h2, 32'h8000_0003);
        wait_done(lat, got, bok);
        n_checks++;
        if (div0_o !== 1'b0 || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'h0000_0006)
            $display("FAIL div0_clear: div0=%b hi=%h lo=%h required 0 ffffffff 00000006", div0_o, hi_o, lo_o);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int extra;
        launch(C_MULT, 32'h1234_5678, 32'h8765_4321);
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0)
            $display("FAIL reset_midop_state: busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
                     busy_o, done_o, hi_o, lo_o);
        else n_pass++;
        extra = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o || hi_o != 0 || lo_o != 0) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL reset_midop_abandon: %0d cycles with activity required 0", extra);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b, ehi, elo;
        logic         edz, got, bok;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand($urandom_range(0, 9), $urandom);
            b  = pick_operand($urandom_range(0, 9), $urandom);
            launch(op, a, b);
            wait_done(lat, got, bok);
            ref_model(op, a, b, ehi, elo, edz);
            n_checks++;
            if (got !== 1'b1 || lat != exp_lat(op, b))
                $display("FAIL rnd%0d_latency: op=%0d done=%b lat=%0d required %0d", i, op, got, lat, exp_lat(op, b));
            else n_pass++;
            n_checks++;
            if (hi_o !== ehi || lo_o !== elo || div0_o !== edz)
                $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                         i, op, a, b, hi_o, lo_o, div0_o, ehi, elo, edz);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_mthi_mtlo();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
